// File: rtl/common_dffram_2a1wb2r.sv
// common_dffram_2a1wb2r: flop-based RAM, port A read-write with bit enables, port B read-only.
// Contents clear to zero on synchronous reset; both reads are combinational.
module common_dffram_2a1wb2r #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] addra,
   input  logic                  ena,
   input  logic [DATA_WIDTH-1:0] wea,
   input  logic [DATA_WIDTH-1:0] dina,
   output logic [DATA_WIDTH-1:0] douta,
   input  logic [ADDR_WIDTH-1:0] addrb,
   output logic [DATA_WIDTH-1:0] doutb
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (ena) begin
         mem[addra] <= (mem[addra] & ~wea) | (dina & wea);
      end
   end
   assign douta = mem[addra];
   assign doutb = mem[addrb];
endmodule

// File: rtl/common_dfffifo_1w1r.sv
// common_dfffifo_1w1r: first-word-fall-through FIFO over a flop RAM, one push and one pop per cycle.
// Define COMMON_DFFFIFO_COUNT_EN to add the occupancy output count.
module common_dfffifo_1w1r #(
   parameter int FIFO_DATA_WIDTH = 1,
   parameter int FIFO_ADDR_WIDTH = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wen,
   input  logic [FIFO_DATA_WIDTH-1:0] din,
   output logic                       wready,
   input  logic                       ren,
   output logic [FIFO_DATA_WIDTH-1:0] dout,
   output logic                       rvalid
`ifdef COMMON_DFFFIFO_COUNT_EN
   ,
   output logic [FIFO_ADDR_WIDTH:0]   count
`endif
);
   localparam int PTR_WIDTH = FIFO_ADDR_WIDTH + 1;
   logic [PTR_WIDTH-1:0] wptr, rptr;
   logic [FIFO_DATA_WIDTH-1:0] douta_unused;
   logic push, pop, full, empty;
   // The extra pointer bit tells a full ring from an empty one.
   assign empty  = wptr == rptr;
   assign full   = (wptr[FIFO_ADDR_WIDTH-1:0] == rptr[FIFO_ADDR_WIDTH-1:0]) &&
                   (wptr[FIFO_ADDR_WIDTH] != rptr[FIFO_ADDR_WIDTH]);
   assign wready = !full;
   assign rvalid = !empty;
   assign push   = wen && !full;
   assign pop    = ren && !empty;
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         wptr <= push ? wptr + 1'b1 : wptr;
         rptr <= pop ? rptr + 1'b1 : rptr;
      end
   end
`ifdef COMMON_DFFFIFO_COUNT_EN
   assign count = wptr - rptr;
`endif
   common_dffram_2a1wb2r #(
      .DATA_WIDTH(FIFO_DATA_WIDTH),
      .ADDR_WIDTH(FIFO_ADDR_WIDTH)
   ) u_ram (
      .clk  (clk),
      .reset(reset),
      .addra(wptr[FIFO_ADDR_WIDTH-1:0]),
      .ena  (push),
      .wea  ({FIFO_DATA_WIDTH{push}}),
      .dina (din),
      .douta(douta_unused),
      .addrb(rptr[FIFO_ADDR_WIDTH-1:0]),
      .doutb(dout)
   );
endmodule

// File: tb/tb_common_dfffifo_1w1r.sv
// tb_common_dfffifo_1w1r: scoreboard bench for common_dfffifo_1w1r at depth 4, 8-bit data.
// A queue model tracks accepted pushes/pops; a negedge monitor compares head and flags.
module tb_common_dfffifo_1w1r;
   localparam int DW = 8;
   localparam int AW = 2;
   localparam int DEPTH = 1 << AW;
   logic clk = 0;
   logic reset = 1;
   logic wen = 0, ren = 0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout;
   logic wready, rvalid;
`ifdef COMMON_DFFFIFO_COUNT_EN
   logic [AW:0] count;
`endif
   int total = 0;
   int bad = 0;
   bit checking = 0;
   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   common_dfffifo_1w1r #(.FIFO_DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .wen(wen), .din(din), .wready(wready),
      .ren(ren), .dout(dout), .rvalid(rvalid)
`ifdef COMMON_DFFFIFO_COUNT_EN
      , .count(count)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a bounded queue updated at each edge from the sampled requests.
   always @(posedge clk) begin
      if (reset) begin
         exp_q.delete();
         checking <= 1;
      end else begin
         int sz;
         sz = exp_q.size();
         if (ren && sz > 0) void'(exp_q.pop_front());
         if (wen && sz < DEPTH) exp_q.push_back(din);
      end
   end

   always @(negedge clk) begin
      if (checking && !reset) begin
         check("mon_rvalid", {31'b0, rvalid}, {31'b0, exp_q.size() != 0});
         check("mon_wready", {31'b0, wready}, {31'b0, exp_q.size() < DEPTH});
         if (exp_q.size() != 0) check("mon_dout", {24'b0, dout}, {24'b0, exp_q[0]});
`ifdef COMMON_DFFFIFO_COUNT_EN
         check("mon_count", {29'b0, count}, exp_q.size());
`endif
      end
   end

   task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
      wen = w;
      din = d;
      ren = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [DW-1:0] vals [4];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      step(1, 8'hFF, 1);
      step(1, 8'hFF, 1);
      reset = 0;
      step(0, 0, 0);
      check("rst_wready", {31'b0, wready}, 1);
      check("rst_rvalid", {31'b0, rvalid}, 0);
      check("rst_dout", {24'b0, dout}, 0);
`ifdef COMMON_DFFFIFO_COUNT_EN
      check("rst_count", {29'b0, count}, 0);
`endif
      for (int i = 0; i < 4; i++) step(1, vals[i], 0);
      check("full_wready", {31'b0, wready}, 0);
      step(1, 8'h55, 0);
      check("drop_wready", {31'b0, wready}, 0);
      for (int i = 0; i < 4; i++) begin
         check("order_dout", {24'b0, dout}, {24'b0, vals[i]});
         step(0, 0, 1);
      end
      check("drain_rvalid", {31'b0, rvalid}, 0);
      step(1, 8'hA5, 1);
      check("fwft_rvalid", {31'b0, rvalid}, 1);
      check("fwft_dout", {24'b0, dout}, 8'hA5);
      step(0, 0, 1);
      check("fwft_empty", {31'b0, rvalid}, 0);
      for (int i = 0; i < 4; i++) step(1, vals[i], 0);
      step(1, 8'h99, 1);
      check("fullrw_wready", {31'b0, wready}, 1);
      check("fullrw_dout", {24'b0, dout}, 8'h22);
      for (int i = 0; i < 200; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      step(0, 0, 1);
      step(0, 0, 1);
      step(0, 0, 1);
      step(0, 0, 1);
      check("rand_drained", {31'b0, rvalid}, 0);
      for (int i = 0; i < 3; i++) step(1, 8'h60 + 8'(i), 0);
      check("pre_rst_rvalid", {31'b0, rvalid}, 1);
      reset = 1;
      step(1, 8'hEE, 1);
      reset = 0;
      check("mid_rst_rvalid", {31'b0, rvalid}, 0);
      check("mid_rst_wready", {31'b0, wready}, 1);
`ifdef COMMON_DFFFIFO_COUNT_EN
      check("mid_rst_count", {29'b0, count}, 0);
`endif
      step(1, 8'h7E, 0);
      check("post_rst_dout", {24'b0, dout}, 8'h7E);
      step(0, 0, 1);
      check("post_rst_empty", {31'b0, rvalid}, 0);
      step(0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
